// File: rtl/tcp_win_rewriter_if.sv
// Streaming word bus used on both sides of tcp_win_rewriter.
//   data : packet word, byte 0 in the most significant lane
//   ctrl : per-word control; zero for payload words, non-zero for module
//          header words and for the last word of a packet (EOP)
//   wr   : word valid, driven by the master
//   rdy  : receiver can accept, driven by the slave
interface tcp_win_rewriter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, output ctrl, output wr, input rdy);
  modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/tcp_win_rewriter.sv
// tcp_win_rewriter: rewrites the TCP receive window of IPv4/TCP packets and
// repairs the TCP checksum incrementally (RFC 1624 eqn. 3). Non-matching
// traffic passes through untouched. Output is combinational from the head of
// a fall-through input FIFO, so no cycles are added on the data path.
//
// Ports:
//   clk, reset        single clock, asynchronous active-high reset
//   in_bus  (slave)   upstream words; in_bus.rdy = !fifo_nearly_full
//   out_bus (master)  downstream words; out_bus.wr asserted with FIFO read
//   reg_*_in/_out     register ring; this block answers addresses whose
//                     upper 17 bits equal RECWIND_MODIFIER_BLOCK_ADDR
//                     idx 0 WIN_MODE[1:0] (0/3 bypass, 1 replace, 2 clamp)
//                     idx 1 WIN_VALUE[15:0], idx 2 PKTS_MODIFIED,
//                     idx 3 PKTS_SKIPPED (counters read-only)
//
// Build option: define TCP_WIN_CLAMP_EN to make mode 2 clamp the window to
// min(window, WIN_VALUE); without it mode 2 is a bypass and no comparator
// is built.
module tcp_win_rewriter #(
  parameter int          DATA_WIDTH                  = 64,
  parameter int          CTRL_WIDTH                  = DATA_WIDTH / 8,
  parameter int          UDP_REG_SRC_WIDTH           = 2,
  parameter int          FIFO_DEPTH_BITS             = 2,
  parameter logic [16:0] RECWIND_MODIFIER_BLOCK_ADDR = 17'h00003
) (
  input  logic                         clk,
  input  logic                         reset,
  tcp_win_rewriter_if.slave            in_bus,
  tcp_win_rewriter_if.master           out_bus,
  input  logic                         reg_req_in,
  input  logic                         reg_ack_in,
  input  logic                         reg_rd_wr_L_in,
  input  logic [22:0]                  reg_addr_in,
  input  logic [31:0]                  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,
  output logic                         reg_req_out,
  output logic                         reg_ack_out,
  output logic                         reg_rd_wr_L_out,
  output logic [22:0]                  reg_addr_out,
  output logic [31:0]                  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] FULL_CNT   = (FIFO_DEPTH_BITS+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_BITS:0] NEARLY_CNT = (FIFO_DEPTH_BITS+1)'(DEPTH - 1);

  typedef enum logic [2:0] {S_HDR, S_WORD2, S_WORD3, S_WORD4_6, S_WORD7, S_PASS} state_t;

  function automatic logic [15:0] pick_window(input logic [1:0]  mode,
                                              input logic [15:0] cur,
                                              input logic [15:0] value);
    case (mode)
      2'd1:    pick_window = value;
`ifdef TCP_WIN_CLAMP_EN
      2'd2:    pick_window = (value < cur) ? value : cur;
`endif
      default: pick_window = cur;
    endcase
  endfunction

  // ~(~HC + ~m + m') with the end-around carry folded twice; the first fold
  // can itself carry out, hence the second.
  function automatic logic [15:0] csum_update(input logic [15:0] hc,
                                              input logic [15:0] old_w,
                                              input logic [15:0] new_w);
    logic [17:0] sum;
    logic [16:0] fold;
    sum  = {2'b00, ~hc} + {2'b00, ~old_w} + {2'b00, new_w};
    fold = {1'b0, sum[15:0]} + {15'b0, sum[17:16]};
    csum_update = ~(fold[15:0] + {15'b0, fold[16]});
  endfunction

  logic [DATA_WIDTH+CTRL_WIDTH-1:0] fifo_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0]       wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_BITS:0]         count;
  logic                             wr_en, rd_en;
  logic [DATA_WIDTH-1:0]            head_data;
  logic [CTRL_WIDTH-1:0]            head_ctrl;

  state_t      state, state_nxt;
  logic [2:0]  word_cnt, cnt_nxt;
  logic        inc_mod, inc_skip;
  logic [DATA_WIDTH-1:0] out_data;

  logic [1:0]  win_mode;
  logic [15:0] win_value;
  logic [31:0] pkts_modified, pkts_skipped;
  logic [31:0] rd_value;
  logic        reg_hit;

  logic        is_eop, ip_ok, tcp_ok, win_changed;
  logic [15:0] new_win, new_csum;

  // Input FIFO
  assign wr_en      = in_bus.wr && (count != FULL_CNT);
  assign rd_en      = (count != '0) && out_bus.rdy;
  assign in_bus.rdy = (count < NEARLY_CNT);
  assign {head_ctrl, head_data} = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= {in_bus.ctrl, in_bus.data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Parser / rewrite, evaluated on the FIFO head
  assign is_eop      = (head_ctrl != '0);
  assign ip_ok       = (head_data[31:16] == 16'h0800) && (head_data[15:8] == 8'h45);
  assign tcp_ok      = (head_data[7:0] == 8'h06) && (head_data[28:16] == 13'h0);
  assign new_win     = pick_window(win_mode, head_data[63:48], win_value);
  assign new_csum    = csum_update(head_data[47:32], head_data[63:48], new_win);
  assign win_changed = (new_win != head_data[63:48]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_HDR;
      word_cnt <= 3'd1;
    end else begin
      state    <= state_nxt;
      word_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = word_cnt;
    inc_mod   = 1'b0;
    inc_skip  = 1'b0;
    out_data  = head_data;
    // The rewritten word is presented while held, so a stalled word 7 stays
    // stable and is counted only on the cycle it is actually consumed.
    if (state == S_WORD7 && win_changed)
      out_data = {new_win, new_csum, head_data[31:0]};
    if (rd_en) begin
      case (state)
        S_HDR: begin
          if (!is_eop) begin
            state_nxt = S_WORD2;
            cnt_nxt   = 3'd2;
          end
        end
        S_WORD2, S_WORD3: begin
          if (is_eop) begin
            inc_skip  = 1'b1;
            state_nxt = S_HDR;
            cnt_nxt   = 3'd1;
          end else if ((state == S_WORD2) ? !ip_ok : !tcp_ok) begin
            inc_skip  = 1'b1;
            state_nxt = S_PASS;
          end else begin
            state_nxt = (state == S_WORD2) ? S_WORD3 : S_WORD4_6;
            cnt_nxt   = word_cnt + 3'd1;
          end
        end
        S_WORD4_6: begin
          if (is_eop) begin
            inc_skip  = 1'b1;
            state_nxt = S_HDR;
            cnt_nxt   = 3'd1;
          end else begin
            cnt_nxt = word_cnt + 3'd1;
            if (word_cnt == 3'd6) state_nxt = S_WORD7;
          end
        end
        S_WORD7: begin
          inc_mod   = win_changed;
          inc_skip  = !win_changed;
          state_nxt = is_eop ? S_HDR : S_PASS;
          cnt_nxt   = 3'd1;
        end
        S_PASS: begin
          if (is_eop) begin
            state_nxt = S_HDR;
            cnt_nxt   = 3'd1;
          end
        end
        default: begin
          state_nxt = S_HDR;
          cnt_nxt   = 3'd1;
        end
      endcase
    end
  end

  assign out_bus.data = out_data;
  assign out_bus.ctrl = head_ctrl;
  assign out_bus.wr   = rd_en;

  // Register ring node: answer unacknowledged requests for this block,
  // forward everything else one cycle later.
  assign reg_hit = reg_req_in && !reg_ack_in &&
                   (reg_addr_in[22:6] == RECWIND_MODIFIER_BLOCK_ADDR);

  always_comb begin
    rd_value = 32'h0;
    case (reg_addr_in[5:0])
      6'd0:    rd_value = {30'h0, win_mode};
      6'd1:    rd_value = {16'h0, win_value};
      6'd2:    rd_value = pkts_modified;
      6'd3:    rd_value = pkts_skipped;
      default: rd_value = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_mode        <= 2'd0;
      win_value       <= 16'hFFFF;
      pkts_modified   <= 32'h0;
      pkts_skipped    <= 32'h0;
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b1;
    end else begin
      if (reg_hit && !reg_rd_wr_L_in) begin
        case (reg_addr_in[5:0])
          6'd0:    win_mode  <= reg_data_in[1:0];
          6'd1:    win_value <= reg_data_in[15:0];
          default: ;
        endcase
      end
      if (inc_mod)  pkts_modified <= pkts_modified + 32'd1;
      if (inc_skip) pkts_skipped  <= pkts_skipped + 32'd1;
      reg_req_out     <= reg_req_in;
      reg_ack_out     <= reg_ack_in | reg_hit;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
    end
  end

  always_ff @(posedge clk) begin
    reg_addr_out <= reg_addr_in;
    reg_src_out  <= reg_src_in;
    reg_data_out <= (reg_hit && reg_rd_wr_L_in) ? rd_value : reg_data_in;
  end

endmodule

// File: doc/tcp_win_rewriter.md
# tcp_win_rewriter

Pipeline stage for the user data path that rewrites the TCP receive window of IPv4/TCP packets and incrementally repairs the TCP checksum (RFC 1624). It is the parametrised successor to the fixed-value window stage: it supports a selectable mode (bypass / replace / clamp), a configurable input FIFO depth and packet counters. Non-matching traffic passes through unchanged. It sits between the output-port lookup and the output queues, and chains on the UDP register ring.

## Interface
- DATA_WIDTH, 64, data bus width (only 64 supported)
- CTRL_WIDTH, DATA_WIDTH/8, control bus width
- UDP_REG_SRC_WIDTH, 2, register-ring source tag width
- FIFO_DEPTH_BITS, 2, log2 input FIFO depth (2..5)

Ports:
- clk  in  1  single clock
- reset  in  1  reset is asynchronous and active-high
- in_data / in_ctrl / in_wr  in  DATA_WIDTH / CTRL_WIDTH / 1  upstream word
- in_rdy  out  1  = !fifo_nearly_full
- out_data / out_ctrl / out_wr  out  DATA_WIDTH / CTRL_WIDTH / 1  downstream word
- out_rdy  in  1  downstream can accept
- reg_req/ack/rd_wr_L/addr/data/src _in / _out  in / out  ring widths  register ring through generic_regs, tag RECWIND_MODIFIER_BLOCK_ADDR
- SW regs: WIN_MODE[1:0] (0 bypass, 1 replace, 2 clamp, 3 bypass) and WIN_VALUE[15:0]
- Counters: PKTS_MODIFIED, PKTS_SKIPPED

## Operation
- Input: fall-through FIFO of depth 2^FIFO_DEPTH_BITS. A word moves when the FIFO is not empty and out_rdy is high; out_wr and rd_en are then asserted in the same cycle.
- States:
  - HDR: passes words with ctrl≠0. The first ctrl==0 word is word 1; go to WORD2.
  - WORD2: match requires ethertype [31:16]==0x0800 and version/IHL [15:8]==0x45; else PASS.
  - WORD3: match requires proto [7:0]==0x06 and fragment offset [28:16]==0; else PASS.
  - WORD4..6: pass through, counting words.
  - WORD7: window is [63:48], checksum is [47:32].
  - PASS: forward words until a word with ctrl≠0 (EOP), then HDR.
- Word 7 rewrite:
  - Old window m, new window m'.
  - replace: m'=WIN_VALUE.
  - clamp: m'=min(m,WIN_VALUE).
  - bypass: m'=m.
  - If m'≠m: window←m', checksum←~(~HC + ~m + m'), 16-bit ones'-complement sum, end-around carry folded twice. Increment PKTS_MODIFIED.
  - Otherwise the word is unchanged and PKTS_SKIPPED is incremented.
- After word 7, go to PASS.
- A parse failure in WORD2/WORD3 increments PKTS_SKIPPED once.
- EOP seen in any state before WORD7 returns to HDR, and the packet counts as skipped.
- WIN_MODE/WIN_VALUE are sampled at WORD7. A write mid-packet affects that packet only if it lands before WORD7.
- Byte lanes are never reordered. out_ctrl always equals the FIFO ctrl.

## Timing
- Zero added cycles: output is combinational from the FIFO head. Latency in_wr→out_wr is 1 cycle when the FIFO was empty.
- Throughput is 1 word/cycle with out_rdy held high.
- Backpressure: in_rdy deasserts at nearly_full, with one slot of slack for an in-flight write.
- Reset values:
  - state=HDR, word count=1, FIFO empty.
  - out_wr=0, in_rdy=1 one cycle after release.
  - Counters 0, WIN_MODE=0, WIN_VALUE=0xFFFF.
- Reset mid-packet: the remainder of the packet is discarded. The next accepted word is treated as a header word.
- out_rdy dropping at WORD7 holds the modified word stable until accepted. The rewrite is recomputed from the held FIFO head, so it is idempotent.

## Configuration
- TCP_WIN_CLAMP_EN defined: mode 2 performs clamp.
- TCP_WIN_CLAMP_EN undefined: mode 2 behaves as bypass, and the min comparator is not synthesised.

## Test plan
- Mode 1, WIN_VALUE=0x0400; TCP packet with window 0xFFFF, checksum 0x1C46 -> word 7 carries window 0x0400, checksum 0x1846; PKTS_MODIFIED=1; all other words bit-identical.
- Mode 2, WIN_VALUE=0x0400; window 0x0200 -> packet unchanged, PKTS_SKIPPED=1. Window 0x8000 -> window 0x0400 with a correct incremental checksum (cross-checked by full recompute).
- ARP (ethertype 0x0806) packet, a UDP (proto 0x11) packet, and an IHL=6 packet -> forwarded unchanged; PKTS_SKIPPED=3.
- 60-byte TCP packet with out_rdy toggling 1/0 every cycle and back-to-back packets -> no word lost or duplicated; each word 7 is modified exactly once.
- reset asserted during word 5 -> out_wr=0 immediately. Next packet with window 0xFFFF, mode 1, value 0x1000 -> rewritten correctly.
- Short packet with EOP at word 4, followed by a TCP packet -> first packet forwarded unchanged and counted as skipped; second packet modified.
